fp_sub_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-precision FP subtractor among NUM_REQ requesters.

---
 rtl/fp_sub_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fp_sub_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_arbiter.sv
// Round-robin arbiter that time-shares one FP subtractor among NUM_REQ clients.
// One operation in flight: accept {a,b}, hand a then b to the subtractor, collect z, return it.
module fp_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            sub_input_a,
  output logic                   sub_input_a_stb,
  input  logic                   sub_input_a_ack,
  output logic [31:0]            sub_input_b,
  output logic                   sub_input_b_stb,
  input  logic                   sub_input_b_ack,
  input  logic [31:0]            sub_output_z,
  input  logic                   sub_output_z_stb,
  output logic                   sub_output_z_ack,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic [CNT_W-1:0]       op_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [31:0]        z_q, z_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               a_stb_q, a_stb_d;
  logic               b_stb_q, b_stb_d;
  logic               z_ack_q, z_ack_d;
  logic               busy_q, busy_d;

  logic [31:0]        req_a_w [NUM_REQ];
  logic [31:0]        req_b_w [NUM_REQ];
  logic               found;
  logic [ID_W-1:0]    pick;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_w[i] = req_a[32*i +: 32];
      req_b_w[i] = req_b[32*i +: 32];
    end
  end

  // Search starts just after the last served requester so everyone gets a turn.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found) begin
      req_ready = NUM_REQ'(1) << pick;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    z_d     = z_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d  = req_a_w[pick];
          op_b_d  = req_b_w[pick];
          grant_d = pick;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (sub_input_a_ack) state_d = SEND_B;
      end
      SEND_B: begin
        if (sub_input_b_ack) state_d = WAIT_Z;
      end
      WAIT_Z: begin
        if (sub_output_z_stb) begin
          z_d     = sub_output_z;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are decoded from the next state so they come straight from flops.
    busy_d      = (state_d != IDLE);
    a_stb_d     = (state_d == SEND_A);
    b_stb_d     = (state_d == SEND_B);
    z_ack_d     = (state_d == WAIT_Z);
    rsp_valid_d = (state_d == RESP) ? (NUM_REQ'(1) << grant_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      z_q         <= '0;
      grant_q     <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      z_q         <= z_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      z_ack_q     <= z_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign sub_input_a      = op_a_q;
  assign sub_input_b      = op_b_q;
  assign sub_input_a_stb  = a_stb_q;
  assign sub_input_b_stb  = b_stb_q;
  assign sub_output_z_ack = z_ack_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = z_q;
  assign busy             = busy_q;
  assign grant_id         = grant_q;
  assign op_count         = cnt_q;

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Randomized bench for fp_sub_arbiter with a stub subtractor and a transaction-level
// reference model of round-robin service.
module tb_fp_sub_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_data, sub_input_a, sub_input_b, sub_output_z;
  logic            sub_input_a_stb, sub_input_a_ack;
  logic            sub_input_b_stb, sub_input_b_ack;
  logic            sub_output_z_stb, sub_output_z_ack;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic [CW-1:0]   op_count;

  always #5 clk = ~clk;

  fp_sub_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .sub_input_a(sub_input_a), .sub_input_a_stb(sub_input_a_stb), .sub_input_a_ack(sub_input_a_ack),
    .sub_input_b(sub_input_b), .sub_input_b_stb(sub_input_b_stb), .sub_input_b_ack(sub_input_b_ack),
    .sub_output_z(sub_output_z), .sub_output_z_stb(sub_output_z_stb), .sub_output_z_ack(sub_output_z_ack),
    .busy(busy), .grant_id(grant_id), .op_count(op_count)
  );

  int checks = 0;
  int errors = 0;

  // requester side of the model
  logic [N-1:0] pend;
  logic [31:0]  pa [N];
  logic [31:0]  pb [N];
  logic [31:0]  last_rsp [N];
  logic [N-1:0] gen_mask;
  int           p_new, p_ack, p_z, p_rdy;

  // service model: one transaction in flight, round-robin after last served
  bit           inflight, a_sent, b_sent, z_got;
  int           cur, last_srv, gid, cnt;
  logic [31:0]  cur_a, cur_b;
  int           grants [$];

  // stub subtractor
  bit           stub_b;
  logic [31:0]  stub_av, stub_bv;

  function automatic logic [31:0] sub_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h41200000 && b == 32'h41200000) return 32'h00000000;
    if (a == 32'h7F800000 && b == 32'h7F800000) return 32'hFFC00000;
    return (a - b) ^ {b[15:0], a[31:16]};
  endfunction

  function automatic int next_grant();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last_srv + k) % N]) return (last_srv + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    inflight = 0; a_sent = 0; b_sent = 0; z_got = 0;
    cur = 0; last_srv = N - 1; gid = 0; cnt = 0;
    stub_b = 0;
    grants.delete();
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_req_ready"}, req_ready, 0);
    checkOutput({pfx, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({pfx, "_rsp_data"}, rsp_data, 0);
    checkOutput({pfx, "_sub_a"}, sub_input_a, 0);
    checkOutput({pfx, "_sub_a_stb"}, sub_input_a_stb, 0);
    checkOutput({pfx, "_sub_b"}, sub_input_b, 0);
    checkOutput({pfx, "_sub_b_stb"}, sub_input_b_stb, 0);
    checkOutput({pfx, "_z_ack"}, sub_output_z_ack, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_grant_id"}, grant_id, 0);
    checkOutput({pfx, "_op_count"}, op_count, 0);
  endtask

  task automatic doReset(input string pfx);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero(pfx);
    modelReset();
    req_valid = '0;
    rsp_ready = '0;
    sub_input_a_ack = 1'b0;
    sub_input_b_ack = 1'b0;
    sub_output_z_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare every output against the model, then advance the model by the
  // handshakes that the coming rising edge will complete.
  task automatic scoreCycle();
    int g;
    logic [N-1:0] exp_ready, exp_rsp;
    exp_ready = '0;
    exp_rsp   = '0;
    g = -1;
    if (!inflight) begin
      g = next_grant();
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    if (inflight && z_got) exp_rsp[cur] = 1'b1;
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("busy", busy, inflight);
    checkOutput("a_stb", sub_input_a_stb, inflight && !a_sent);
    if (inflight && !a_sent) checkOutput("a_data", sub_input_a, cur_a);
    checkOutput("b_stb", sub_input_b_stb, inflight && a_sent && !b_sent);
    if (inflight && a_sent && !b_sent) checkOutput("b_data", sub_input_b, cur_b);
    checkOutput("z_ack", sub_output_z_ack, inflight && b_sent && !z_got);
    checkOutput("rsp_valid", rsp_valid, exp_rsp);
    if (inflight && z_got) checkOutput("rsp_data", rsp_data, sub_fn(cur_a, cur_b));
    checkOutput("grant_id", grant_id, gid);
    checkOutput("op_count", op_count, cnt % (1 << CW));

    if (inflight && z_got) begin
      if (rsp_ready[cur]) begin
        last_rsp[cur] = rsp_data;
        inflight = 0;
        last_srv = cur;
        cnt++;
      end
    end else if (inflight && b_sent) begin
      if (sub_output_z_stb) begin
        z_got  = 1;
        stub_b = 0;
      end
    end else if (inflight && a_sent) begin
      if (sub_input_b_ack) begin
        b_sent  = 1;
        stub_b  = 1;
        stub_bv = sub_input_b;
      end
    end else if (inflight) begin
      if (sub_input_a_ack) begin
        a_sent  = 1;
        stub_av = sub_input_a;
      end
    end else if (g >= 0) begin
      inflight = 1; a_sent = 0; b_sent = 0; z_got = 0;
      cur = g; gid = g; cur_a = pa[g]; cur_b = pb[g];
      pend[g] = 1'b0;
      grants.push_back(g);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (gen_mask[i] && !pend[i] && $urandom_range(99) < p_new) begin
        pend[i] = 1'b1;
        pa[i]   = $urandom;
        pb[i]   = $urandom;
      end
      req_valid[i]      = pend[i];
      req_a[32*i +: 32] = pend[i] ? pa[i] : $urandom;
      req_b[32*i +: 32] = pend[i] ? pb[i] : $urandom;
      rsp_ready[i]      = ($urandom_range(99) < p_rdy);
    end
    sub_input_a_ack = ($urandom_range(99) < p_ack);
    sub_input_b_ack = ($urandom_range(99) < p_ack);
    if (stub_b) begin
      sub_output_z_stb = ($urandom_range(99) < p_z);
      sub_output_z     = sub_fn(stub_av, stub_bv);
    end else begin
      sub_output_z_stb = ($urandom_range(99) < 10);
      sub_output_z     = $urandom;
    end
    #1;
    scoreCycle();
  endtask

  task automatic setKnobs(input logic [N-1:0] m, input int pn, input int pa_, input int pz, input int pr);
    gen_mask = m; p_new = pn; p_ack = pa_; p_z = pz; p_rdy = pr;
  endtask

  initial begin
    int n;
    pend = '0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    sub_input_a_ack = 1'b0; sub_input_b_ack = 1'b0;
    sub_output_z_stb = 1'b0; sub_output_z = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0; pb[i] = '0; last_rsp[i] = '0;
    end
    stub_av = '0; stub_bv = '0; cur_a = '0; cur_b = '0;
    setKnobs('0, 0, 100, 100, 100);
    doReset("rst0");

    // single op, then the zero and inf-inf pass-through vectors
    pend[0] = 1'b1; pa[0] = 32'h40400000; pb[0] = 32'h3F800000;
    repeat (12) applyStimulus();
    checkOutput("t1_result", last_rsp[0], 32'h40000000);
    checkOutput("t1_count", op_count, 1);
    pend[1] = 1'b1; pa[1] = 32'h41200000; pb[1] = 32'h41200000;
    pend[2] = 1'b1; pa[2] = 32'h7F800000; pb[2] = 32'h7F800000;
    repeat (20) applyStimulus();
    checkOutput("t7_zero", last_rsp[1], 32'h00000000);
    checkOutput("t7_inf", last_rsp[2], 32'hFFC00000);

    // all four valid from reset: served 0,1,2,3
    doReset("rst1");
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pa[i] = 32'h3F000000 + i; pb[i] = 32'h00010000 * (i + 1);
    end
    repeat (40) applyStimulus();
    checkOutput("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) checkOutput("t2_order", grants[i], i);

    // req0 and req2 continuously valid: strict alternation
    doReset("rst2");
    setKnobs(4'b0101, 100, 70, 70, 70);
    repeat (120) applyStimulus();
    checkOutput("t3_enough", grants.size() >= 6, 1);
    for (int i = 0; i < grants.size(); i++) checkOutput("t3_alt", grants[i], (i % 2) * 2);

    // response and subtractor back-pressure phases
    setKnobs(4'b1111, 60, 100, 100, 0);
    repeat (15) applyStimulus();
    setKnobs(4'b1111, 60, 0, 100, 100);
    repeat (15) applyStimulus();
    setKnobs(4'b1111, 60, 100, 0, 100);
    repeat (15) applyStimulus();

    // broad random traffic
    setKnobs(4'b1111, 30, 50, 50, 50);
    repeat (2000) applyStimulus();

    // reset while waiting for z, with other requests pending
    setKnobs(4'b1111, 100, 100, 0, 100);
    n = 0;
    while (!(inflight && b_sent && !z_got) && n < 60) begin
      applyStimulus();
      n++;
    end
    checkOutput("t6_reach_wait_z", inflight && b_sent && !z_got, 1);
    @(posedge clk);
    #2;
    checkOutput("t6_pre_z_ack", sub_output_z_ack, 1);
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom;
      end
      req_valid[i] = 1'b1;
    end
    doReset("t6");
    setKnobs(4'b1111, 100, 100, 100, 100);
    repeat (10) applyStimulus();
    checkOutput("t6_first_grant", grants.size() > 0 ? grants[0] : -1, 0);

    setKnobs(4'b1111, 40, 60, 60, 60);
    repeat (800) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
